// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter with bounded burst lock sharing one data memory between two masters
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MAXLOCK = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic          lock0,
   input  logic          lock1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          stall0,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   localparam logic [1:0] NONE = 2'd0, P0 = 2'd1, P1 = 2'd2;
   logic [1:0] owner, owner_n;
   logic [3:0] lockcnt, lockcnt_n;
   logic       last, last_eff, hold;
   assign gnt0      = (owner == P0) & req0;
   assign gnt1      = (owner == P1) & req1;
   assign stall0    = req0 & ~gnt0;
   assign mem_we    = gnt0 ? we0 : (gnt1 & we1);
   assign mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
   assign mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
   // the grant in flight counts as "last" so that contending ports alternate every cycle
   assign last_eff  = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last;
   always_comb begin
      hold = ((owner == P0) & req0 & lock0 & ((lockcnt < 4'(MAXLOCK)) | ~req1)) |
             ((owner == P1) & req1 & lock1 & ((lockcnt < 4'(MAXLOCK)) | ~req0));
      owner_n = hold ? owner : (req0 & req1) ? (last_eff ? P0 : P1) : req0 ? P0 : req1 ? P1 : NONE;
      lockcnt_n = hold ? ((lockcnt == 4'hf) ? lockcnt : lockcnt + 4'd1) :
                  ((owner_n != owner) | (owner_n == NONE)) ? 4'd0 : lockcnt;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         owner   <= NONE;
         last    <= 1'b1;
         lockcnt <= 4'd0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata   <= '0;
      end else begin
         owner   <= owner_n;
         last    <= last_eff;
         lockcnt <= lockcnt_n;
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
         if ((gnt0 & ~we0) | (gnt1 & ~we1)) rdata <= mem_rdata;
      end
   end
endmodule
